// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct codes, ALU op codes, state codes and datapath select codes
package mips_ctrl_pkg;
  localparam int ALU_OP_W = 4;
  localparam int STATE_W = 4;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_JR = 4'b1000;
  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_RS = 2'b01;
  localparam logic [1:0] SRCA_RT = 2'b10;
  localparam logic [2:0] SRCB_B = 3'b000;
  localparam logic [2:0] SRCB_4 = 3'b001;
  localparam logic [2:0] SRCB_SEXT = 3'b010;
  localparam logic [2:0] SRCB_BR = 3'b011;
  localparam logic [2:0] SRCB_SHAMT = 3'b100;
  localparam logic [2:0] SRCB_ZEXT = 3'b101;
  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC = 2'b10;
  typedef enum logic [STATE_W-1:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
    S_JR_EXEC = 4'd12, S_ILLEGAL = 4'd13
  } state_t;
  function automatic logic opcode_ok(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic r_funct_ok(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [ALU_OP_W-1:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      FN_ADD: return ALU_ADD;
      FN_SUB: return ALU_SUB;
      FN_OR: return ALU_OR;
      FN_NOR: return ALU_NOR;
      FN_SLL: return ALU_SLL;
      FN_SRL: return ALU_SRL;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [ALU_OP_W-1:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI: return ALU_OR;
      OP_LUI: return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: per-state ALU operation/operand selects and illegal-instruction detection
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  state_t              state,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic [1:0]          alu_src_a,
  output logic [2:0]          alu_src_b,
  output logic                illegal
);
  logic shift, rknown;
  assign shift = funct == FN_SLL || funct == FN_SRL;
  assign rknown = r_funct_ok(funct);
  // Unlisted selects stay 0; illegal flags a bad opcode in DECODE or a bad funct in R_EXEC
  always_comb begin
    alu_operation = ALU_AND;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_B;
    illegal = 1'b0;
    case (state)
      S_FETCH: begin
        alu_operation = ALU_ADD;
        alu_src_b = SRCB_4;
      end
      S_DECODE: begin
        alu_operation = ALU_ADD;
        alu_src_b = SRCB_BR;
        illegal = !opcode_ok(opcode);
      end
      S_MEM_ADDR: begin
        alu_operation = ALU_ADD;
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_SEXT;
      end
      S_R_EXEC: begin
        alu_operation = r_alu_op(funct);
        alu_src_a = shift ? SRCA_RT : rknown ? SRCA_RS : SRCA_PC;
        alu_src_b = shift ? SRCB_SHAMT : SRCB_B;
        illegal = !rknown;
      end
      S_I_EXEC: begin
        alu_operation = i_alu_op(opcode);
        alu_src_a = SRCA_RS;
        alu_src_b = opcode == OP_ADDI ? SRCB_SEXT : SRCB_ZEXT;
      end
      S_BRANCH: begin
        alu_operation = ALU_SUB;
        alu_src_a = SRCA_RS;
      end
      S_JR_EXEC: begin
        alu_operation = ALU_JR;
        alu_src_a = SRCA_RS;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM; MEM_WAIT_EN adds a mem_ready handshake on memory states
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                jr,
`ifdef MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic [1:0]          alu_src_a,
  output logic [2:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic                pc_en,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [STATE_W-1:0]  state
);
  state_t st;
  logic illegal, rdy, jal;
`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif
  alu_op_decoder u_dec (
    .opcode(opcode),
    .funct(funct),
    .state(st),
    .alu_operation(alu_operation),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .illegal(illegal)
  );
  // Instruction walk FETCH..WB; memory states wait for rdy, everything else advances every cycle
  always_ff @(posedge clk) begin
    if (!reset) st <= S_FETCH;
    else case (st)
      S_FETCH: st <= rdy ? S_DECODE : S_FETCH;
      S_DECODE: st <= illegal ? S_ILLEGAL :
                      opcode == OP_RTYPE ? (funct == FN_JR ? S_JR_EXEC : S_R_EXEC) :
                      (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                      (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                      (opcode == OP_J || opcode == OP_JAL) ? S_JUMP : S_I_EXEC;
      S_MEM_ADDR: st <= opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: st <= rdy ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: st <= rdy ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC: st <= illegal ? S_ILLEGAL : S_R_WB;
      S_I_EXEC: st <= S_I_WB;
      default: st <= S_FETCH;
    endcase
  end
  assign jal = opcode == OP_JAL;
  assign state = st;
  assign mem_read = reset & (st == S_FETCH | st == S_MEM_READ);
  assign mem_write = reset & st == S_MEM_WRITE;
  assign ir_write = reset & st == S_FETCH & rdy;
  assign pc_en = reset & (st == S_FETCH ? rdy : st == S_JUMP ? 1'b1 :
                          st == S_BRANCH ? (opcode == OP_BNE ? !zero : zero) :
                          st == S_JR_EXEC ? jr : 1'b0);
  assign reg_write = reset & (st == S_MEM_WB | st == S_R_WB | st == S_I_WB | (st == S_JUMP & jal));
  assign i_or_d = st == S_MEM_READ | st == S_MEM_WRITE;
  assign pc_source = st == S_BRANCH ? PCS_ALUOUT : st == S_JUMP ? PCS_JUMP : PCS_ALU;
  assign reg_dst = st == S_R_WB ? DST_RD : (st == S_JUMP & jal) ? DST_RA : DST_RT;
  assign mem_to_reg = st == S_MEM_WB ? M2R_MDR : (st == S_JUMP & jal) ? M2R_PC : M2R_ALUOUT;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and random instruction walks checked against a per-instruction reference model
`timescale 1ns/1ps
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, jr = 1'b0;
`ifdef MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif
  logic [3:0] alu_operation, state;
  logic [1:0] alu_src_a, pc_source, reg_dst, mem_to_reg;
  logic [2:0] alu_src_b;
  logic pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .jr(jr),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .alu_operation(alu_operation), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic rdy, pc_en, mrd, mwr, irw, rw, iod;
    logic [3:0] aop;
    logic [1:0] sa;
    logic [2:0] sb;
    logic [1:0] ps, rd, m2r;
  } rec_t;

  rec_t q[$];
  int passes = 0, fails = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] s);
    rec_t r;
    r = '0;
    r.st = s;
    r.rdy = 1'b1;
    return r;
  endfunction

  // Expected cycle-by-cycle walk of one instruction, derived from its class
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic j,
                       input int wf, input int wm);
    rec_t r;
    logic ok;
    q.delete();
    for (int i = 0; i <= wf; i++) begin
      r = mk(0); r.rdy = (i == wf); r.mrd = 1; r.irw = r.rdy; r.pc_en = r.rdy;
      r.sb = 3'b001; r.aop = 4'b0011; q.push_back(r);
    end
    r = mk(1); r.sb = 3'b011; r.aop = 4'b0011; q.push_back(r);
    if (op == 6'h00 && fn == 6'h08) begin
      r = mk(12); r.aop = 4'b1000; r.sa = 2'b01; r.pc_en = j; q.push_back(r);
    end else if (op == 6'h00) begin
      r = mk(6); ok = 1; r.sa = 2'b01;
      case (fn)
        6'h20: r.aop = 4'b0011;
        6'h22: r.aop = 4'b0111;
        6'h24: r.aop = 4'b0000;
        6'h25: r.aop = 4'b0001;
        6'h27: r.aop = 4'b0101;
        6'h00: begin r.aop = 4'b0100; r.sa = 2'b10; r.sb = 3'b100; end
        6'h02: begin r.aop = 4'b0110; r.sa = 2'b10; r.sb = 3'b100; end
        default: ok = 0;
      endcase
      if (ok) begin
        q.push_back(r);
        r = mk(7); r.rw = 1; r.rd = 2'b01; q.push_back(r);
      end else begin
        q.push_back(mk(6));
        q.push_back(mk(13));
      end
    end else if (op == 6'h23 || op == 6'h2B) begin
      r = mk(2); r.aop = 4'b0011; r.sa = 2'b01; r.sb = 3'b010; q.push_back(r);
      for (int i = 0; i <= wm; i++) begin
        r = mk(op == 6'h23 ? 4'd3 : 4'd5); r.rdy = (i == wm); r.iod = 1;
        r.mrd = (op == 6'h23); r.mwr = (op == 6'h2B); q.push_back(r);
      end
      if (op == 6'h23) begin
        r = mk(4); r.rw = 1; r.m2r = 2'b01; q.push_back(r);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      r = mk(8); r.aop = 4'b0111; r.sa = 2'b01; r.ps = 2'b01;
      r.pc_en = (op == 6'h04) ? z : !z; q.push_back(r);
    end else if (op == 6'h02 || op == 6'h03) begin
      r = mk(9); r.ps = 2'b10; r.pc_en = 1;
      if (op == 6'h03) begin r.rw = 1; r.rd = 2'b10; r.m2r = 2'b10; end
      q.push_back(r);
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0F) begin
      r = mk(10); r.sa = 2'b01; r.sb = (op == 6'h08) ? 3'b010 : 3'b101;
      r.aop = op == 6'h08 ? 4'b0011 : op == 6'h0C ? 4'b0000 : op == 6'h0D ? 4'b0001 : 4'b0010;
      q.push_back(r);
      r = mk(11); r.rw = 1; q.push_back(r);
    end else begin
      q.push_back(mk(13));
    end
  endtask

  task automatic check(input rec_t e, input string t);
    chk({t, ".state"}, 32'(state), 32'(e.st));
    chk({t, ".pc_en"}, 32'(pc_en), 32'(e.pc_en));
    chk({t, ".mem_read"}, 32'(mem_read), 32'(e.mrd));
    chk({t, ".mem_write"}, 32'(mem_write), 32'(e.mwr));
    chk({t, ".ir_write"}, 32'(ir_write), 32'(e.irw));
    chk({t, ".reg_write"}, 32'(reg_write), 32'(e.rw));
    chk({t, ".i_or_d"}, 32'(i_or_d), 32'(e.iod));
    chk({t, ".alu_op"}, 32'(alu_operation), 32'(e.aop));
    chk({t, ".src_a"}, 32'(alu_src_a), 32'(e.sa));
    chk({t, ".src_b"}, 32'(alu_src_b), 32'(e.sb));
    chk({t, ".pc_source"}, 32'(pc_source), 32'(e.ps));
    chk({t, ".reg_dst"}, 32'(reg_dst), 32'(e.rd));
    chk({t, ".mem_to_reg"}, 32'(mem_to_reg), 32'(e.m2r));
  endtask

  task automatic walk(input int n, input string t);
    for (int i = 0; i < n; i++) begin
`ifdef MEM_WAIT_EN
      mem_ready = q[i].rdy;
`endif
      #1;
      check(q[i], $sformatf("%s.step%0d", t, i));
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic j,
                     input int wf, input int wm);
    string t;
`ifndef MEM_WAIT_EN
    wf = 0; wm = 0;
`endif
    opcode = op; funct = fn; zero = z; jr = j;
    t = $sformatf("op%0h_fn%0h_z%0d_j%0d", op, fn, z, j);
    build(op, fn, z, j, wf, wm);
    walk(q.size(), t);
  endtask

  task automatic hold_reset(input int n, input string t);
    reset = 1'b0;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk({t, ".state"}, 32'(state), 32'd0);
      chk({t, ".enables"}, 32'({pc_en, mem_read, mem_write, ir_write, reg_write}), 32'd0);
    end
    reset = 1'b1;
    #1;
  endtask

  logic [5:0] ops[13];
  logic [5:0] fns[8];

  initial begin
    logic [5:0] op, fn;
    int k;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
    hold_reset(3, "reset");
    run(6'h00, 6'h20, 0, 0, 0, 0);
    run(6'h23, 6'h11, 0, 0, 0, 0);
    run(6'h2B, 6'h11, 0, 0, 0, 0);
    run(6'h04, 6'h00, 1, 0, 0, 0);
    run(6'h04, 6'h00, 0, 0, 0, 0);
    run(6'h05, 6'h00, 0, 0, 0, 0);
    run(6'h05, 6'h00, 1, 0, 0, 0);
    run(6'h00, 6'h08, 0, 1, 0, 0);
    run(6'h00, 6'h08, 0, 0, 0, 0);
    run(6'h3F, 6'h00, 0, 0, 0, 0);
    run(6'h02, 6'h00, 0, 0, 0, 0);
    run(6'h03, 6'h00, 0, 0, 0, 0);
    run(6'h08, 6'h00, 0, 0, 0, 0);
    run(6'h0C, 6'h00, 0, 0, 0, 0);
    run(6'h0D, 6'h00, 0, 0, 0, 0);
    run(6'h0F, 6'h00, 0, 0, 0, 0);
    run(6'h00, 6'h00, 0, 0, 0, 0);
    run(6'h00, 6'h02, 0, 0, 0, 0);
    run(6'h00, 6'h3F, 0, 0, 0, 0);
`ifdef MEM_WAIT_EN
    run(6'h02, 6'h00, 0, 0, 4, 0);
    run(6'h23, 6'h00, 0, 0, 1, 3);
    run(6'h2B, 6'h00, 0, 0, 0, 2);
`endif
    opcode = 6'h23; funct = 6'h00;
    build(6'h23, 6'h00, 0, 0, 0, 0);
    walk(3, "lw_abort");
    reset = 1'b0;
    #1;
    chk("abort.state", 32'(state), 32'd3);
    chk("abort.mem_read", 32'(mem_read), 32'd0);
    chk("abort.reg_write", 32'(reg_write), 32'd0);
    hold_reset(2, "abort_reset");
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 13);
      op = (k == 13) ? 6'($urandom) : ops[k];
      k = $urandom_range(0, 8);
      fn = (k == 8) ? 6'($urandom) : fns[k];
      run(op, fn, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
